// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo_arb block: FSM state encoding and a
// constant-evaluable ceil(log2) helper used to size counters and indices.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Smallest number of bits able to index 'value' distinct items (min 1).
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin search: the first set request found starting
// one past 'last' and wrapping, returned as a one-hot vector (zero if none).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   last,
    output logic [N-1:0]          pick
);

    localparam int LW = clog2(N);

    logic [LW-1:0] idx_s;
    logic          found_s;

    // Walk the ring once from last+1; only the first hit sets its pick bit.
    always_comb begin
        pick    = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s       = LW'((int'(last) + k) % N);
            pick[idx_s] = req[idx_s] & ~found_s;
            found_s     = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/fifo_arb.sv
// N-way round-robin arbiter feeding one shared downstream FIFO; a grant lasts
// up to B transfers and is always followed by one IDLE arbitration cycle.
module fifo_arb
    import fifo_arb_pkg::*;
#(
    parameter int dw = 8,
    parameter int N  = 4,
    parameter int B  = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N*dw-1:0] d_in,
    input  logic [N-1:0]    req_in,
    output logic [N-1:0]    ack_in,
    output logic [dw-1:0]   d_out,
    output logic            req_out,
    input  logic            ack_out,
    output logic [N-1:0]    gnt
);

    localparam int            LW       = clog2(N);
    localparam int            CW       = clog2(B + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(B - 1);
    localparam logic [LW-1:0] LAST_RST = LW'(N - 1);

    state_t        state_r, state_nxt_s;
    logic [N-1:0]  gnt_r, gnt_nxt_s, pick_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [LW-1:0] last_r, last_nxt_s, gidx_r, gidx_nxt_s, pick_idx_s;
    logic          granted_s, xfer_s;

    rr_pick #(.N(N)) u_rr_pick (
        .req  (req_in),
        .last (last_r),
        .pick (pick_s)
    );

    // One-hot pick to binary index; the granted index is kept alongside gnt.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            pick_idx_s = pick_idx_s | (pick_s[i] ? LW'(i) : LW'(0));
        end
    end

    // Output mux; ack_out reaches only ack_in, everything else follows state.
    always_comb begin
        granted_s = (state_r == ST_GRANT);
        req_out   = 1'b0;
        d_out     = '0;
        ack_in    = '0;
        if (granted_s) begin
            req_out = req_in[gidx_r];
            d_out   = d_in[int'(gidx_r) * dw +: dw];
            ack_in  = gnt_r & {N{ack_out}};
        end else begin
            req_out = 1'b0;
            d_out   = '0;
            ack_in  = '0;
        end
        xfer_s = granted_s & req_out & ack_out;
    end

    // Next-state logic: arbitrate in IDLE, count transfers in GRANT.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_r;
        gidx_nxt_s  = gidx_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_in) begin
                    state_nxt_s = ST_GRANT;
                    gnt_nxt_s   = pick_s;
                    gidx_nxt_s  = pick_idx_s;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = '0;
                end
            end
            ST_GRANT: begin
                // Release on requester drop or on the final transfer of the burst.
                if (!req_in[gidx_r] || (xfer_s && (cnt_r == CNT_LAST))) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = '0;
                    cnt_nxt_s   = '0;
                    last_nxt_s  = gidx_r;
                end else if (xfer_s) begin
                    cnt_nxt_s = cnt_r + CW'(1'b1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = '0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            cnt_r   <= '0;
            last_r  <= LAST_RST;
            gidx_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
            gidx_r  <= gidx_nxt_s;
        end
    end

    assign gnt = gnt_r;

endmodule

// File: tb/tb_fifo_arb.sv
// Directed vector table plus hand-written corner sequences and a random
// scoreboard run for fifo_arb (dw=8, N=4, B=4, with a B=1 companion).
module tb_fifo_arb;

    logic        clk;
    logic        rstn;
    logic [31:0] d_in;
    logic [3:0]  req_in;
    logic        ack_out;
    logic [3:0]  ack_in, gnt, ack_in1, gnt1;
    logic [7:0]  d_out, d_out1;
    logic        req_out, req_out1;

    int n_vec;
    int n_err;

    fifo_arb #(.dw(8), .N(4), .B(4)) dut (
        .clk(clk), .rstn(rstn), .d_in(d_in), .req_in(req_in), .ack_in(ack_in),
        .d_out(d_out), .req_out(req_out), .ack_out(ack_out), .gnt(gnt)
    );

    fifo_arb #(.dw(8), .N(4), .B(1)) dut1 (
        .clk(clk), .rstn(rstn), .d_in(d_in), .req_in(req_in), .ack_in(ack_in1),
        .d_out(d_out1), .req_out(req_out1), .ack_out(ack_out), .gnt(gnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic [3:0] req;
        logic       ack;
        logic [3:0] gnt;
        logic       rq_o;
        logic [3:0] ack_i;
        logic [7:0] dout;
    } vec_t;

    vec_t        vecs[17];
    logic [31:0] dconst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_d(input logic [3:0] g, input logic [31:0] d);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (g[k]) r = d[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic drive(input logic r, input logic [3:0] rq, input logic a);
        @(negedge clk);
        rstn    = r;
        req_in  = rq;
        ack_out = a;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn   = 1'b0;
        req_in = 4'b0000;
        d_in   = dconst;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic erq,
                           input logic [3:0] eai, input logic [7:0] ed);
        chk({tag, ".gnt"},     32'(gnt),     32'(eg));
        chk({tag, ".req_out"}, 32'(req_out), 32'(erq));
        chk({tag, ".ack_in"},  32'(ack_in),  32'(eai));
        chk({tag, ".d_out"},   32'(d_out),   32'(ed));
    endtask

    initial begin
        logic [3:0] eg, eg1, acc, prev_g;
        logic [5:0] sc[4];
        int         burst, ch;

        n_vec   = 0;
        n_err   = 0;
        rstn    = 1'b0;
        req_in  = 4'b0000;
        ack_out = 1'b1;
        dconst  = 32'hD3C2B1A0;
        d_in    = dconst;

        vecs[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};
        vecs[1]  = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};
        vecs[2]  = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[3]  = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[4]  = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[5]  = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[6]  = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};
        vecs[7]  = '{1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hC2};
        vecs[8]  = '{1'b1, 4'b0101, 1'b0, 4'b0100, 1'b1, 4'b0000, 8'hC2};
        vecs[9]  = '{1'b1, 4'b0111, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hC2};
        vecs[10] = '{1'b1, 4'b1101, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hC2};
        vecs[11] = '{1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'hC2};
        vecs[12] = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};
        vecs[13] = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0};
        vecs[14] = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, 8'hA0};
        vecs[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};
        vecs[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rstn, vecs[i].req, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rq_o, vecs[i].ack_i, vecs[i].dout);
        end

        // All requesting: B=4 rotates 0,1,2,3,0 with 1-cycle gaps; B=1 releases every transfer.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            drive(1'b1, 4'b1111, 1'b1);
            eg  = (c % 5 == 0) ? 4'b0000 : 4'(4'b0001 << ((c / 5) % 4));
            eg1 = (c % 2 == 0) ? 4'b0000 : 4'(4'b0001 << ((c / 2) % 4));
            chk_all($sformatf("rr%0d", c), eg, |eg, eg, exp_d(eg, dconst));
            chk($sformatf("b1_gnt%0d", c), 32'(gnt1), 32'(eg1));
        end

        // Channel 2 drops its request after two transfers; search resumes at 3.
        do_reset();
        drive(1'b1, 4'b0100, 1'b1); chk_all("drop0", 4'b0000, 1'b0, 4'b0000, 8'h00);
        drive(1'b1, 4'b0100, 1'b1); chk_all("drop1", 4'b0100, 1'b1, 4'b0100, 8'hC2);
        drive(1'b1, 4'b0100, 1'b1); chk_all("drop2", 4'b0100, 1'b1, 4'b0100, 8'hC2);
        drive(1'b1, 4'b1011, 1'b1); chk_all("drop3", 4'b0100, 1'b0, 4'b0100, 8'hC2);
        drive(1'b1, 4'b1011, 1'b1); chk_all("drop4", 4'b0000, 1'b0, 4'b0000, 8'h00);
        drive(1'b1, 4'b1011, 1'b1); chk_all("drop5", 4'b1000, 1'b1, 4'b1000, 8'hD3);

        // Ten-cycle downstream stall mid-burst; burst then completes at 4 transfers.
        do_reset();
        drive(1'b1, 4'b0001, 1'b1); chk_all("stall_idle", 4'b0000, 1'b0, 4'b0000, 8'h00);
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 4'b0001, 1'b1); chk_all("stall_pre", 4'b0001, 1'b1, 4'b0001, 8'hA0);
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 4'b0001, 1'b0); chk_all($sformatf("stall%0d", c), 4'b0001, 1'b1, 4'b0000, 8'hA0);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 4'b0001, 1'b1); chk_all("stall_post", 4'b0001, 1'b1, 4'b0001, 8'hA0);
        end
        drive(1'b1, 4'b0001, 1'b1); chk_all("stall_end", 4'b0000, 1'b0, 4'b0000, 8'h00);

        // Reset pulse during channel 1's burst aborts it; channel 0 wins next.
        do_reset();
        for (int c = 0; c < 7; c++) drive(1'b1, 4'b1111, 1'b1);
        chk_all("rst_pre", 4'b0010, 1'b1, 4'b0010, 8'hB1);
        drive(1'b0, 4'b1111, 1'b1); chk_all("rst_low", 4'b0010, 1'b1, 4'b0010, 8'hB1);
        drive(1'b1, 4'b1111, 1'b1); chk_all("rst_after", 4'b0000, 1'b0, 4'b0000, 8'h00);
        drive(1'b1, 4'b1111, 1'b1); chk_all("rst_regrant", 4'b0001, 1'b1, 4'b0001, 8'hA0);

        // Random scoreboard: each channel offers a sequence-numbered stream.
        do_reset();
        for (int k = 0; k < 4; k++) sc[k] = 6'd0;
        burst  = 0;
        prev_g = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rstn    = 1'b1;
            for (int k = 0; k < 4; k++) d_in[k*8 +: 8] = {2'(k), sc[k]};
            req_in  = 4'($urandom_range(0, 15));
            ack_out = 1'($urandom_range(0, 1));
            #1;
            acc = req_in & ack_in;
            if (gnt != prev_g || gnt == 4'b0000) burst = 0;
            if (gnt != 4'b0000 && prev_g != 4'b0000 && gnt != prev_g)
                chk("sb_gap", 32'(gnt), 32'(4'b0000));
            if (req_out && ack_out) begin
                chk("sb_onehot", 32'($countones(acc)), 32'd1);
                ch = 0;
                for (int k = 0; k < 4; k++) if (acc[k]) ch = k;
                chk("sb_data", 32'(d_out), 32'({2'(ch), sc[ch]}));
                sc[ch] = sc[ch] + 6'd1;
                burst++;
                if (burst > 4) chk("sb_burst", 32'(burst), 32'd4);
            end else begin
                chk("sb_noacc", 32'(acc), 32'd0);
            end
            prev_g = gnt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
